// File: rtl/game_pkg.sv
// game_pkg: state encoding and default game constants shared by the player life logic.
package game_pkg;
    typedef enum logic [2:0] {PLAY, DYING, INVULN, LEVEL_WON, GAME_OVER} life_state_t;
    localparam int INIT_LIVES_DEF    = 3;
    localparam int INVULN_FRAMES_DEF = 60;
    localparam int DEATH_FRAMES_DEF  = 45;
endpackage

// File: rtl/frame_timer.sv
// frame_timer: loadable down-counter stepped once per frame; done marks the last frame.
module frame_timer #(
    parameter int TIMER_W = 7
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               startOfFrame,
    output logic [TIMER_W-1:0] count,
    output logic               done
);
    always_ff @(posedge clk or negedge resetN)
        if (!resetN)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (startOfFrame && count != '0)
            count <= count - TIMER_W'(1);

    assign done = startOfFrame && count == TIMER_W'(1);
endmodule

// File: rtl/player_life_manager.sv
// player_life_manager: condenses per-pixel collisions into one event per frame, tracks lives and
// runs the play/dying/invulnerable/won/over FSM. Define PLAYER_BLINK_EN to blink while invulnerable.
module player_life_manager
    import game_pkg::*;
#(
    parameter int INIT_LIVES    = INIT_LIVES_DEF,
    parameter int LIVES_W       = 3,
    parameter int INVULN_FRAMES = INVULN_FRAMES_DEF,
    parameter int DEATH_FRAMES  = DEATH_FRAMES_DEF,
    parameter int TIMER_W       = 7
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               player_hit,
    input  logic               player_door_idol,
    input  logic               all_enemies_dead,
    input  logic               restart,
    output logic [LIVES_W-1:0] lives,
    output logic               player_invulnerable,
    output logic               player_dying,
    output logic               player_respawn,
    output logic               level_won,
    output logic               game_over,
    output logic               player_blink
);
    if (DEATH_FRAMES == 0 || INVULN_FRAMES == 0) begin : g_zero_frames
        $error("player_life_manager: DEATH_FRAMES and INVULN_FRAMES must be nonzero");
    end
    if (INIT_LIVES >= 2**LIVES_W || DEATH_FRAMES >= 2**TIMER_W || INVULN_FRAMES >= 2**TIMER_W) begin : g_widths
        $error("player_life_manager: LIVES_W or TIMER_W too narrow");
    end

    life_state_t        state, state_next;
    logic [LIVES_W-1:0] lives_r, lives_next;
    logic               hit_pend, door_pend, restart_go;
    logic               timer_load, timer_done;
    logic [TIMER_W-1:0] timer_val, timer_count;

    assign restart_go = restart && (state == LEVEL_WON || state == GAME_OVER);

    // An overlap in the startOfFrame clk itself belongs to the next frame.
    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            hit_pend  <= 1'b0;
            door_pend <= 1'b0;
        end else begin
            hit_pend  <= !restart_go && (player_hit || (hit_pend && !startOfFrame));
            door_pend <= !restart_go && ((player_door_idol && all_enemies_dead) || (door_pend && !startOfFrame));
        end

    always_comb begin
        state_next     = state;
        lives_next     = lives_r;
        player_respawn = 1'b0;
        case (state)
            PLAY:
                if (startOfFrame && hit_pend) begin
                    state_next = DYING;
                    lives_next = lives_r == '0 ? '0 : lives_r - LIVES_W'(1);
                end else if (startOfFrame && door_pend)
                    state_next = LEVEL_WON;
            DYING:
                if (timer_done) begin
                    state_next     = lives_r == '0 ? GAME_OVER : INVULN;
                    player_respawn = lives_r != '0;
                end
            INVULN:
                if (startOfFrame && door_pend)
                    state_next = LEVEL_WON;
                else if (timer_done)
                    state_next = PLAY;
            LEVEL_WON, GAME_OVER:
                if (restart) begin
                    state_next     = PLAY;
                    lives_next     = LIVES_W'(INIT_LIVES);
                    player_respawn = 1'b1;
                end
            default: state_next = PLAY;
        endcase
    end

    assign timer_load = state_next != state;
    assign timer_val  = state_next == DYING  ? TIMER_W'(DEATH_FRAMES) :
                        state_next == INVULN ? TIMER_W'(INVULN_FRAMES) : '0;

    frame_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk          (clk),
        .resetN       (resetN),
        .load         (timer_load),
        .load_val     (timer_val),
        .startOfFrame (startOfFrame),
        .count        (timer_count),
        .done         (timer_done)
    );

    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            state               <= PLAY;
            lives_r             <= LIVES_W'(INIT_LIVES);
            lives               <= LIVES_W'(INIT_LIVES);
            player_invulnerable <= 1'b0;
            player_dying        <= 1'b0;
            level_won           <= 1'b0;
            game_over           <= 1'b0;
        end else begin
            state               <= state_next;
            lives_r             <= lives_next;
            lives               <= lives_r;
            player_invulnerable <= state == DYING || state == INVULN;
            player_dying        <= state == DYING;
            level_won           <= state == LEVEL_WON;
            game_over           <= state == GAME_OVER;
        end

`ifdef PLAYER_BLINK_EN
    // Frames spent in INVULN are recovered from the shared timer, so no extra counter is needed.
    logic [TIMER_W-1:0] invuln_elapsed;
    assign invuln_elapsed = TIMER_W'(INVULN_FRAMES) - timer_count;
    always_ff @(posedge clk or negedge resetN)
        if (!resetN)
            player_blink <= 1'b1;
        else
            player_blink <= state != INVULN || invuln_elapsed[2];
`else
    assign player_blink = 1'b1;
`endif
endmodule

// File: tb/tb_player_life_manager.sv
// tb_player_life_manager: frame-level reference model feeding an expected-output scoreboard.
module tb_player_life_manager;
    import game_pkg::*;

    localparam int FLEN = 6;

    typedef struct {
        int lives;
        int inv;
        int dying;
        int won;
        int over;
        int blink;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       player_hit = 1'b0;
    logic       player_door_idol = 1'b0;
    logic       all_enemies_dead = 1'b0;
    logic       restart = 1'b0;
    logic [2:0] lives;
    logic       player_invulnerable, player_dying, player_respawn;
    logic       level_won, game_over, player_blink;

    int n_cmp = 0, n_err = 0;
    int resp_cnt = 0, run = 0, max_run = 0;
    exp_t sbq[$];

    life_state_t m_state;
    int  m_lives, m_timer, m_cnt, m_resp;
    bit  m_hp, m_dp;

    player_life_manager dut (
        .clk                 (clk),
        .resetN              (resetN),
        .startOfFrame        (startOfFrame),
        .player_hit          (player_hit),
        .player_door_idol    (player_door_idol),
        .all_enemies_dead    (all_enemies_dead),
        .restart             (restart),
        .lives               (lives),
        .player_invulnerable (player_invulnerable),
        .player_dying        (player_dying),
        .player_respawn      (player_respawn),
        .level_won           (level_won),
        .game_over           (game_over),
        .player_blink        (player_blink)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (resetN) begin
            if (player_respawn) begin
                resp_cnt++;
                run++;
                if (run > max_run) max_run = run;
            end else
                run = 0;
        end

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = PLAY; m_lives = 3; m_timer = 0; m_cnt = 0; m_hp = 0; m_dp = 0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.lives = m_lives;
        e.inv   = int'(m_state == DYING || m_state == INVULN);
        e.dying = int'(m_state == DYING);
        e.won   = int'(m_state == LEVEL_WON);
        e.over  = int'(m_state == GAME_OVER);
`ifdef PLAYER_BLINK_EN
        e.blink = m_state == INVULN ? (m_cnt >> 2) & 1 : 1;
`else
        e.blink = 1;
`endif
        sbq.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({tag, ".queue"}, 0, 1);
            return;
        end
        e = sbq.pop_front();
        chk({tag, ".lives"}, 32'(lives), e.lives);
        chk({tag, ".invuln"}, 32'(player_invulnerable), e.inv);
        chk({tag, ".dying"}, 32'(player_dying), e.dying);
        chk({tag, ".won"}, 32'(level_won), e.won);
        chk({tag, ".over"}, 32'(game_over), e.over);
        chk({tag, ".blink"}, 32'(player_blink), e.blink);
    endtask

    // Reference behaviour at each startOfFrame, using events gathered in the previous frame.
    task automatic model_sof();
        case (m_state)
            PLAY:
                if (m_hp) begin
                    m_state = DYING; m_timer = 45; m_lives = m_lives > 0 ? m_lives - 1 : 0;
                end else if (m_dp)
                    m_state = LEVEL_WON;
            DYING:
                if (m_timer == 1) begin
                    if (m_lives == 0) m_state = GAME_OVER;
                    else begin
                        m_state = INVULN; m_timer = 60; m_cnt = 0; m_resp++;
                    end
                end else
                    m_timer--;
            INVULN:
                if (m_dp) m_state = LEVEL_WON;
                else if (m_timer == 1) m_state = PLAY;
                else begin
                    m_timer--; m_cnt++;
                end
            default: ;
        endcase
        m_hp = 0; m_dp = 0;
    endtask

    task automatic run_frame(input int hits, input bit door, input bit aed, input string tag);
        @(posedge clk); #1 startOfFrame = 1'b1;
        @(posedge clk); #1 startOfFrame = 1'b0;
        push_exp();
        compare({tag, ".pre"});
        model_sof();
        for (int i = 0; i < FLEN; i++) begin
            player_hit = i < hits; player_door_idol = door; all_enemies_dead = aed;
            @(posedge clk); #1;
        end
        player_hit = 1'b0; player_door_idol = 1'b0; all_enemies_dead = 1'b0;
        push_exp();
        compare({tag, ".post"});
        chk({tag, ".respawns"}, resp_cnt, m_resp);
        m_hp = hits > 0; m_dp = door && aed;
    endtask

    task automatic do_restart(input string tag);
        @(posedge clk); #1 restart = 1'b1;
        @(posedge clk); #1 restart = 1'b0;
        push_exp();
        compare({tag, ".pre"});
        if (m_state == LEVEL_WON || m_state == GAME_OVER) begin
            m_state = PLAY; m_lives = 3; m_timer = 0; m_resp++; m_hp = 0; m_dp = 0;
        end
        @(posedge clk); #1;
        push_exp();
        compare({tag, ".post"});
        chk({tag, ".respawns"}, resp_cnt, m_resp);
    endtask

    initial begin
        m_resp = 0;
        model_reset();
        #2 resetN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push_exp();
        compare("reset");
        chk("reset.respawn", 32'(player_respawn), 0);
        resetN = 1'b1;

        run_frame(5, 0, 0, "hit1");
        run_frame(2, 0, 0, "dying_hit");
        for (int i = 0; i < 200 && m_state != PLAY; i++) run_frame(i % 2, 0, 0, "recover");
        for (int i = 0; i < 500 && m_state != GAME_OVER; i++)
            run_frame(m_state == PLAY ? 1 : 0, 0, 0, "to_over");
        run_frame(0, 0, 0, "over_hold");
        do_restart("restart_over");
        do_restart("restart_play");

        run_frame(0, 1, 0, "door_noaed");
        run_frame(0, 0, 0, "door_noaed2");
        run_frame(0, 1, 1, "door");
        run_frame(0, 0, 0, "door_won");
        run_frame(2, 1, 1, "won_hold");
        do_restart("restart_won");

        run_frame(1, 0, 0, "hit_inv");
        for (int i = 0; i < 100 && m_state != INVULN; i++) run_frame(0, 0, 0, "to_inv");
        repeat (9) run_frame(1, 0, 0, "inv_blink");
        run_frame(0, 1, 1, "inv_door");
        run_frame(0, 0, 0, "inv_won");
        do_restart("restart_won2");

        run_frame(3, 1, 1, "hit_door");
        run_frame(0, 0, 0, "hit_door_dying");
        run_frame(0, 0, 0, "dying_more");

        @(posedge clk); #3 resetN = 1'b0;
        #1;
        model_reset();
        push_exp();
        compare("mid_reset");
        chk("mid_reset.respawn", 32'(player_respawn), 0);
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
        run_frame(0, 0, 0, "after_reset");

        chk("respawn_width", max_run, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
